// File: rtl/fetch_pc_gen.sv
// Instruction fetch front end: sequential PC generation, in-order imem
// requests, a 2-entry skid buffer for returned words, and redirect handling
// that discards responses still in flight from the old path.
module fetch_pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = 32'h0000_0000,
  parameter int              MAX_INFLIGHT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [XLEN-1:0]   imem_resp_data,
  input  logic              fifo_full,
  output logic              fifo_wn,
  output logic [2*XLEN-1:0] fifo_wdata
);

  // Counter width must hold os + sc, which can transiently reach MAX_INFLIGHT + 2.
  localparam int              CW      = $clog2(MAX_INFLIGHT + 3);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);
  localparam logic [XLEN-1:0] ALIGN_M = {{(XLEN-2){1'b1}}, 2'b00};

  logic [XLEN-1:0]   fetch_pc_r;
  logic [XLEN-1:0]   resp_pc_r;
  logic [CW-1:0]     os_r;
  logic [CW-1:0]     drop_r;
  logic [1:0]        sc_r;
  logic [2*XLEN-1:0] skid0_r;
  logic [2*XLEN-1:0] skid1_r;

  logic [CW-1:0]     occ_s;
  logic              req_valid_s;
  logic              wn_s;
  logic              accept_s;
  logic              resp_s;
  logic              keep_s;
  logic [XLEN-1:0]   target_s;
  logic [2*XLEN-1:0] entry_s;

  // Request and queue-write qualification; both are held off during reset and redirect.
  always_comb begin
    occ_s       = os_r + CW'(sc_r);
    req_valid_s = 1'b0;
    wn_s        = 1'b0;
    if (reset) begin
      req_valid_s = 1'b0;
      wn_s        = 1'b0;
    end else begin
      req_valid_s = !redirect_valid && (occ_s < CW'(MAX_INFLIGHT));
      wn_s        = (sc_r != 2'd0) && !fifo_full && !redirect_valid;
    end
  end

  // Handshake decode: a response only counts while something is outstanding.
  always_comb begin
    accept_s = req_valid_s && imem_req_ready;
    resp_s   = imem_resp_valid && (os_r != {CW{1'b0}});
    keep_s   = resp_s && (drop_r == {CW{1'b0}});
    target_s = redirect_pc & ALIGN_M;
    entry_s  = {resp_pc_r, imem_resp_data};
  end

  // Fetch/response PCs and the outstanding/drop counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_r <= RESET_PC;
      resp_pc_r  <= RESET_PC;
      os_r       <= {CW{1'b0}};
      drop_r     <= {CW{1'b0}};
    end else if (redirect_valid) begin
      // Everything still outstanding belongs to the old path; the word
      // arriving this very cycle is already accounted for and thrown away.
      fetch_pc_r <= target_s;
      resp_pc_r  <= target_s;
      os_r       <= os_r - CW'(resp_s);
      drop_r     <= os_r - CW'(resp_s);
    end else begin
      if (accept_s) begin
        fetch_pc_r <= fetch_pc_r + PC_STEP;
      end else begin
        fetch_pc_r <= fetch_pc_r;
      end
      if (keep_s) begin
        resp_pc_r <= resp_pc_r + PC_STEP;
      end else begin
        resp_pc_r <= resp_pc_r;
      end
      if (resp_s && (drop_r != {CW{1'b0}})) begin
        drop_r <= drop_r - {{(CW-1){1'b0}}, 1'b1};
      end else begin
        drop_r <= drop_r;
      end
      os_r <= os_r + CW'(accept_s) - CW'(resp_s);
    end
  end

  // Skid buffer: skid0 is always the head; pushes go to the first free slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      sc_r    <= 2'd0;
      skid0_r <= {(2*XLEN){1'b0}};
      skid1_r <= {(2*XLEN){1'b0}};
    end else if (redirect_valid) begin
      sc_r <= 2'd0;
    end else begin
      case ({keep_s, wn_s})
        2'b10: begin
          if (sc_r == 2'd0) begin
            skid0_r <= entry_s;
            sc_r    <= 2'd1;
          end else begin
            skid1_r <= entry_s;
            sc_r    <= 2'd2;
          end
        end
        2'b01: begin
          skid0_r <= skid1_r;
          sc_r    <= sc_r - 2'd1;
        end
        2'b11: begin
          // Push and pop together: count is unchanged, order preserved.
          if (sc_r == 2'd1) begin
            skid0_r <= entry_s;
          end else begin
            skid0_r <= skid1_r;
            skid1_r <= entry_s;
          end
        end
        default: begin
          sc_r <= sc_r;
        end
      endcase
    end
  end

  // Output mapping.
  always_comb begin
    imem_req_valid = req_valid_s;
    imem_req_addr  = fetch_pc_r;
    fifo_wn        = wn_s;
    fifo_wdata     = skid0_r;
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen. A small in-order memory model answers
// accepted requests one cycle later with addr ^ 32'hC0DE_0000; every queue
// write is logged and compared against a hand-derived PC sequence.
module tb_fetch_pc_gen;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        fifo_full;
  logic        fifo_wn;
  logic [63:0] fifo_wdata;

  int tests = 0;
  int fails = 0;

  logic [31:0] mq[$];
  logic [63:0] wlog[$];
  logic        resp_en;
  logic        s_req;
  logic [31:0] s_addr;
  logic        s_wn;
  logic [63:0] s_wdata;

  fetch_pc_gen #(.XLEN(32), .RESET_PC(32'h0000_0000), .MAX_INFLIGHT(2)) dut (
    .clock(clock), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .fifo_full(fifo_full), .fifo_wn(fifo_wn), .fifo_wdata(fifo_wdata)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [63:0] ent(input logic [31:0] pc);
    return {pc, mem_word(pc)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle, entered at a falling edge with inputs already set by the caller.
  task automatic cyc();
    if (reset) mq.delete();
    if (!reset && resp_en && mq.size() > 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mq.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
    #1;
    s_req   = imem_req_valid;
    s_addr  = imem_req_addr;
    s_wn    = fifo_wn;
    s_wdata = fifo_wdata;
    if (!reset && imem_req_valid && imem_req_ready) mq.push_back(imem_req_addr);
    if (fifo_wn) wlog.push_back(fifo_wdata);
    @(negedge clock);
  endtask

  logic [31:0] exp_pc [13];
  logic [63:0] got;

  initial begin
    exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C,
               32'h100, 32'h200, 32'h204, 32'h0, 32'h4};
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1; fifo_full = 1'b0; resp_en = 1'b1;
    imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    @(negedge clock);

    // Reset state
    cyc();
    check("rst_req_valid", 64'(s_req), 64'd0);
    check("rst_wn", 64'(s_wn), 64'd0);
    check("rst_wdata", s_wdata, 64'd0);
    check("rst_addr", 64'(s_addr), 64'h0);
    reset = 1'b0;

    // Stream start: first requests, no response-to-write bypass
    cyc();
    check("c0_req_valid", 64'(s_req), 64'd1);
    check("c0_addr", 64'(s_addr), 64'h0);
    check("c0_wn", 64'(s_wn), 64'd0);
    cyc();
    check("c1_addr", 64'(s_addr), 64'h4);
    check("c1_wn_no_bypass", 64'(s_wn), 64'd0);
    cyc();
    check("c2_req_full_occ", 64'(s_req), 64'd0);
    check("c2_wn", 64'(s_wn), 64'd1);
    check("c2_wdata", s_wdata, ent(32'h0));

    // Memory not ready: address held at 0x8
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_valid", 64'(s_req), 64'd1);
      check("stall_addr", 64'(s_addr), 64'h8);
    end
    imem_req_ready = 1'b1;
    cyc();
    check("stall_accept_addr", 64'(s_addr), 64'h8);
    repeat (4) cyc();

    // Queue full for 10 cycles: skid fills to 2, no requests, no writes
    fifo_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("full_req_valid", 64'(s_req), 64'd0);
      check("full_wn", 64'(s_wn), 64'd0);
    end
    check("full_head", s_wdata, ent(32'h10));
    fifo_full = 1'b0;
    repeat (5) cyc();
    check("pre_redirect_writes", 64'(wlog.size()), 64'd8);

    // Build os=2 by holding responses, then redirect with one response in flight
    resp_en = 1'b0;
    cyc();
    check("os2_addr", 64'(s_addr), 64'h24);
    resp_en = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    cyc();
    check("redir_req_valid", 64'(s_req), 64'd0);
    check("redir_wn", 64'(s_wn), 64'd0);
    redirect_valid = 1'b0;
    cyc();
    check("redir_new_addr", 64'(s_addr), 64'h100);
    check("redir_new_valid", 64'(s_req), 64'd1);
    cyc();
    cyc();
    check("redir_first_wn", 64'(s_wn), 64'd1);
    check("redir_first_wdata", s_wdata, ent(32'h100));

    // Misaligned redirect with a word sitting in the skid
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
    cyc();
    check("mis_redir_wn", 64'(s_wn), 64'd0);
    check("mis_redir_req", 64'(s_req), 64'd0);
    redirect_valid = 1'b0;
    cyc();
    check("mis_addr", 64'(s_addr), 64'h200);
    cyc();
    cyc();
    check("mis_wn", 64'(s_wn), 64'd1);
    check("mis_wdata", s_wdata, ent(32'h200));
    cyc();

    // Fill the skid, then reset mid-operation
    fifo_full = 1'b1;
    cyc();
    cyc();
    cyc();
    check("prereset_head", s_wdata, ent(32'h208));
    check("prereset_req", 64'(s_req), 64'd0);
    reset = 1'b1; fifo_full = 1'b0;
    cyc();
    check("reset_wn", 64'(s_wn), 64'd0);
    check("reset_req", 64'(s_req), 64'd0);
    cyc();
    check("reset_wdata_cleared", s_wdata, 64'd0);
    check("reset_addr", 64'(s_addr), 64'h0);
    reset = 1'b0;
    cyc();
    check("restart_valid", 64'(s_req), 64'd1);
    check("restart_addr", 64'(s_addr), 64'h0);
    check("restart_no_stale_wn", 64'(s_wn), 64'd0);
    repeat (3) cyc();

    // Complete write history: no loss, duplication or stale PC
    check("write_count", 64'(wlog.size()), 64'd13);
    for (int i = 0; i < 13; i++) begin
      got = (i < wlog.size()) ? wlog[i] : 64'hFFFF_FFFF_FFFF_FFFF;
      check("write_seq", got, ent(exp_pc[i]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
